regfile_issue: RTL and testbench
================================

Name: regfile_issue

Overview:
- Operand-supply end of the ALU interface. Holds the 32 x XLEN integer register file and a busy scoreboard.
- Accepts issue requests (rs1, rs2, rd, ALU op) and presents registered operands plus ctrl to the ALU one cycle later.
- Takes the ALU/writeback result back into the file.
- Stalls issue on RAW/WAW hazards and on ALU backpressure.

Parameters:
- XLEN, 32, data width of registers and operands.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, register address width, equal to clog2(NREG).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- iss_valid  in  1  issue request present.
- iss_ready  out  1  issue can be accepted this cycle.
- iss_rs1  in  AW  source register 1 address.
- iss_rs2  in  AW  source register 2 address.
- iss_rd  in  AW  destination register address.
- iss_ctrl  in  3  ALU op (ADD 000, SUB 001, AND 010, OR 011, SLT 101).
- ex_valid  out  1  operands valid toward the ALU.
- ex_ready  in  1  ALU accepts the current operands.
- ex_rs1  out  XLEN  operand 1 to the ALU.
- ex_rs2  out  XLEN  operand 2 to the ALU.
- ex_ctrl  out  3  ALU op to the ALU.
- ex_rd  out  AW  destination tag travelling with the op.
- wb_valid  in  1  writeback strobe.
- wb_addr  in  AW  writeback register address.
- wb_data  in  XLEN  writeback value (ALU rd).
- sb_err  out  1  one-cycle pulse on writeback to a non-busy register other than x0.

Behaviour:
- Reset is sampled at posedge only. When asserted:
  - All registers are cleared to 0 and all busy bits to 0.
  - ex_valid, ex_rs1, ex_rs2, ex_ctrl, ex_rd and sb_err are driven to 0.
  - Reset mid-operation drops any pending ex op and all reservations. A wb_valid in the reset cycle is ignored.
- Effective busy: busy_eff[r] = busy[r] & ~(wb_valid & wb_addr==r). busy[0] is always 0.
- iss_ready = ~busy_eff[rs1] & ~busy_eff[rs2] & ~busy_eff[rd] & (~ex_valid | ex_ready). It is combinational.
- Accept condition: iss_valid & iss_ready at posedge. On the next cycle:
  - ex_valid=1, ex_ctrl=iss_ctrl, ex_rd=iss_rd.
  - ex_rs1 and ex_rs2 take the register values, with writeback bypass: if wb_valid & wb_addr==rsN & wb_addr!=0 in the accept cycle, the operand is wb_data.
  - Reading x0 always yields 0.
  - Latency from issue to operands is 1 cycle.
- Reservation: on accept with iss_rd!=0, busy[iss_rd] is set.
  - Setting a busy bit and clearing the same bit in the same cycle is legal, because the clear freed it. Set wins.
- Writeback: wb_valid & wb_addr!=0 writes wb_data at posedge and clears busy[wb_addr].
  - A write to x0 is discarded.
  - A write to a non-busy register is still performed, and sb_err pulses for 1 cycle.
- ex hold:
  - ex_valid & ~ex_ready: all ex_* outputs hold stable and iss_ready=0.
  - ex_valid & ex_ready with no new accept: ex_valid falls next cycle, and the data outputs hold their last value.
- Simultaneous events: an accept, a writeback and an ex handshake may all occur in one cycle. Each is applied independently per the rules above.

Decomposition:
- riscy_pkg holds:
  - XLEN and NREG constants.
  - reg_addr_t (logic [AW-1:0]).
  - alu_op_t enum (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101), shared with the ALU.
- One sub-module, regfile_scoreboard: busy vector, busy_eff, set/clear logic and sb_err generation.
- Register array and ex pipeline register stay in the top level.

Test Plan:
1. Reset: assert rst_n=0 for 2 cycles, release, issue rs1=5 rs2=6 rd=7 ADD -> next cycle ex_valid=1, ex_rs1=0, ex_rs2=0, ex_ctrl=000, ex_rd=7; busy[7]=1.
2. Basic operands: wb x5=20, then wb x6=30, then issue rs1=5 rs2=6 rd=8 SLT -> ex_rs1=20, ex_rs2=30, ex_ctrl=101, ex_rd=8.
3. RAW hazard with bypass: with x8 busy, issue rs1=8 -> iss_ready=0 for 3 cycles; wb x8=50 in the same cycle as issue -> accepted, ex_rs1=50, busy[8] clear unless rd=8.
4. x0 handling: wb x0=123 -> sb_err=0, read x0 gives 0; issue rd=0 -> no reservation; the immediately following issue with rs1=0 is accepted.
5. Backpressure: ex_valid=1, ex_ready=0 for 3 cycles -> ex_rs1, ex_rs2, ex_ctrl, ex_rd stable and iss_ready=0; ex_ready=1 -> next queued issue lands one cycle later.
6. Mid-operation reset and sb_err: reserve x9, assert rst_n=0 for 1 cycle -> ex_valid=0, busy[9]=0, x5 reads 0; then wb x9=7 -> x9=7 and sb_err pulses for 1 cycle.

Source files
------------

// File: rtl/riscy_pkg.sv
// Shared types and constants for the integer issue path.
// Register addressing, ALU op encoding, issue-to-ex bundle.
package riscy_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      ctrl;
    reg_addr_t       rd;
  } id_ex_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservation on issue, release on writeback.
// Ports: set_i/set_addr_i reserve, wb_* release, busy_eff_o, sb_err_o.
module regfile_scoreboard
  import riscy_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_i,
  input  logic [AW-1:0]   set_addr_i,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_addr_i,
  output logic [NREG-1:0] busy_eff_o,
  output logic            sb_err_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            sb_err_q, sb_err_d;
  logic            wb_live;

  assign wb_live = wb_valid_i && (wb_addr_i != '0);

  // A writeback landing this cycle already frees its register.
  always_comb begin
    busy_eff_o = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_eff_o[r] = busy_q[r] &
        ~(wb_valid_i && (wb_addr_i == AW'(r)));
    end
  end

  // Clear first, then set: a same-cycle re-reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_live)
      busy_d[wb_addr_i] = 1'b0;
    if (set_i && (set_addr_i != '0))
      busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    sb_err_d = wb_live && !busy_q[wb_addr_i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err_o = sb_err_q;

endmodule

// File: rtl/regfile_issue.sv
// Register file + issue stage feeding registered operands to the ALU.
// Ports: iss_* request, ex_* ALU side, wb_* writeback, sb_err pulse.
module regfile_issue
  import riscy_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic [2:0]      iss_ctrl,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [2:0]      ex_ctrl,
  output logic [AW-1:0]   ex_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            sb_err
);

  logic [XLEN-1:0] rf_q [NREG];
  id_ex_t          ex_q, ex_d;
  logic [NREG-1:0] busy_eff;
  logic            accept;
  logic            wb_live;

  assign wb_live = wb_valid && (wb_addr != '0);

  regfile_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (accept),
    .set_addr_i (iss_rd),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .busy_eff_o (busy_eff),
    .sb_err_o   (sb_err)
  );

  assign iss_ready = ~busy_eff[iss_rs1] &
                     ~busy_eff[iss_rs2] &
                     ~busy_eff[iss_rd] &
                     (~ex_q.valid | ex_ready);

  assign accept = iss_valid & iss_ready;

  // Read port with same-cycle writeback forwarding; x0 reads zero.
  function automatic logic [XLEN-1:0] rd_op(
    input logic [AW-1:0] a
  );
    if (a == '0)
      return '0;
    if (wb_live && (wb_addr == a))
      return wb_data;
    return rf_q[a];
  endfunction

  always_comb begin
    ex_d = ex_q;
    if (accept) begin
      ex_d.valid = 1'b1;
      ex_d.rs1   = rd_op(iss_rs1);
      ex_d.rs2   = rd_op(iss_rs2);
      ex_d.ctrl  = iss_ctrl;
      ex_d.rd    = iss_rd;
    end else if (ex_ready) begin
      ex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (wb_live) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign ex_valid = ex_q.valid;
  assign ex_rs1   = ex_q.rs1;
  assign ex_rs2   = ex_q.rs2;
  assign ex_ctrl  = ex_q.ctrl;
  assign ex_rd    = ex_q.rd;

endmodule

// File: tb/tb_regfile_issue.sv
// Directed bench for regfile_issue with an expected-op queue.
// Drives and samples 1 time unit after each rising edge.
module tb_regfile_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [2:0]  iss_ctrl;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_rs1, ex_rs2;
  logic [2:0]  ex_ctrl;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        sb_err;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int   n_assert = 0;
  int   n_fail   = 0;

  regfile_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_ctrl  (iss_ctrl),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .ex_ctrl   (ex_ctrl),
    .ex_rd     (ex_rd),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .sb_err    (sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [2:0] op);
    iss_valid = 1'b1;
    iss_rs1   = r1;
    iss_rs2   = r2;
    iss_rd    = rd;
    iss_ctrl  = op;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [4:0] rd);
    exp_t e;
    e.rs1 = a; e.rs2 = b; e.ctrl = op; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      last = exp_q.pop_front();
      chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd1);
      chk({tag, "_rs1"}, ex_rs1, last.rs1);
      chk({tag, "_rs2"}, ex_rs2, last.rs2);
      chk({tag, "_ctrl"}, {29'd0, ex_ctrl}, {29'd0, last.ctrl});
      chk({tag, "_rd"}, {27'd0, ex_rd}, {27'd0, last.rd});
    end
  endtask

  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; ex_ready = 1'b1;
    iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_ctrl = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;

    // 1: reset, first issue
    tick(); tick();
    chk("rst_exv", {31'd0, ex_valid}, 32'd0);
    chk("rst_rs1", ex_rs1, 32'd0);
    chk("rst_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_err", {31'd0, sb_err}, 32'd0);
    rst_n = 1'b1;
    issue(5, 6, 7, 3'b000);
    #1 chk("t1_rdy", {31'd0, iss_ready}, 32'd1);
    push(0, 0, 3'b000, 7);
    tick();
    iss_valid = 1'b0;
    pop_check("t1");
    iss_rs1 = 7; iss_rs2 = 0; iss_rd = 0;
    #1 chk("t1_busy7", {31'd0, iss_ready}, 32'd0);

    // 2: writes then read
    wb_valid = 1'b1; wb_addr = 5; wb_data = 32'd20;
    tick();
    chk("t2_err5", {31'd0, sb_err}, 32'd1);
    wb_addr = 6; wb_data = 32'd30;
    tick();
    chk("t2_err6", {31'd0, sb_err}, 32'd1);
    wb_valid = 1'b0;
    issue(5, 6, 8, 3'b101);
    push(20, 30, 3'b101, 8);
    tick();
    iss_valid = 1'b0;
    pop_check("t2");
    chk("t2_errlo", {31'd0, sb_err}, 32'd0);

    // 3: RAW stall, release via same-cycle bypass
    issue(8, 0, 9, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_stall", {31'd0, iss_ready}, 32'd0);
      tick();
    end
    wb_valid = 1'b1; wb_addr = 8; wb_data = 32'd50;
    #1 chk("t3_rdy", {31'd0, iss_ready}, 32'd1);
    push(50, 0, 3'b000, 9);
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0;
    pop_check("t3");
    chk("t3_err", {31'd0, sb_err}, 32'd0);
    iss_rs1 = 8; iss_rs2 = 0; iss_rd = 0;
    #1 chk("t3_free8", {31'd0, iss_ready}, 32'd1);

    // 4: x0 writes and reads
    wb_valid = 1'b1; wb_addr = 0; wb_data = 32'd123;
    issue(0, 0, 0, 3'b000);
    push(0, 0, 3'b000, 0);
    tick();
    wb_valid = 1'b0;
    pop_check("t4a");
    chk("t4_err", {31'd0, sb_err}, 32'd0);
    issue(0, 5, 0, 3'b011);
    #1 chk("t4_rdy", {31'd0, iss_ready}, 32'd1);
    push(0, 20, 3'b011, 0);
    tick();
    pop_check("t4b");

    // 5: backpressure holds ex outputs
    ex_ready = 1'b0;
    issue(6, 5, 11, 3'b001);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_stall", {31'd0, iss_ready}, 32'd0);
      chk("t5_hold1", ex_rs1, last.rs1);
      chk("t5_hold2", ex_rs2, last.rs2);
      chk("t5_holdc", {29'd0, ex_ctrl}, {29'd0, last.ctrl});
      chk("t5_holdd", {27'd0, ex_rd}, {27'd0, last.rd});
      tick();
    end
    ex_ready = 1'b1;
    #1 chk("t5_rdy", {31'd0, iss_ready}, 32'd1);
    push(30, 20, 3'b001, 11);
    tick();
    iss_valid = 1'b0;
    pop_check("t5");
    tick();
    chk("t5_drop", {31'd0, ex_valid}, 32'd0);
    chk("t5_keep", ex_rs1, 32'd30);

    // 6: mid-operation reset, then unreserved writeback
    issue(5, 6, 12, 3'b000);
    push(20, 30, 3'b000, 12);
    tick();
    iss_valid = 1'b0;
    pop_check("t6a");
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_addr = 5; wb_data = 32'd99;
    tick();
    rst_n = 1'b1; wb_valid = 1'b0;
    chk("t6_exv", {31'd0, ex_valid}, 32'd0);
    chk("t6_rs1", ex_rs1, 32'd0);
    chk("t6_err", {31'd0, sb_err}, 32'd0);
    iss_rs1 = 9; iss_rs2 = 12; iss_rd = 11;
    #1 chk("t6_free", {31'd0, iss_ready}, 32'd1);
    issue(5, 0, 0, 3'b000);
    push(0, 0, 3'b000, 0);
    tick();
    iss_valid = 1'b0;
    pop_check("t6b");
    wb_valid = 1'b1; wb_addr = 9; wb_data = 32'd7;
    tick();
    wb_valid = 1'b0;
    chk("t6_errhi", {31'd0, sb_err}, 32'd1);
    tick();
    chk("t6_errlo", {31'd0, sb_err}, 32'd0);
    issue(9, 9, 0, 3'b010);
    push(7, 7, 3'b010, 0);
    tick();
    iss_valid = 1'b0;
    pop_check("t6c");

    // 7: same-cycle release and re-reserve keeps the bit set
    issue(0, 0, 13, 3'b000);
    push(0, 0, 3'b000, 13);
    tick();
    pop_check("t7a");
    wb_valid = 1'b1; wb_addr = 13; wb_data = 32'd77;
    #1 chk("t7_rdy", {31'd0, iss_ready}, 32'd1);
    push(0, 0, 3'b000, 13);
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0;
    pop_check("t7b");
    chk("t7_err", {31'd0, sb_err}, 32'd0);
    iss_rs1 = 13; iss_rs2 = 0; iss_rd = 0;
    #1 chk("t7_busy", {31'd0, iss_ready}, 32'd0);
    issue(13, 13, 0, 3'b000);
    wb_valid = 1'b1; wb_addr = 13; wb_data = 32'd88;
    push(88, 88, 3'b000, 0);
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0;
    pop_check("t7c");
    chk("t7_qdone", exp_q.size(), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
